// File: rtl/mgmt_gpio_in_sync.sv
// ---------------------------------------------------------------------------
// mgmt_gpio_in_sync
//
// Purpose:
//    Brings the buffered management GPIO pad inputs into the wb_clk_i domain.
//    Each pad goes through three steps:
//       1. A multi-flop synchroniser.
//       2. An optional debounce filter.
//       3. Rise/fall edge capture into sticky status bits.
//    All status bits are ORed into one registered interrupt. This block sits
//    between the pad buffer stage and the housekeeping register file.
//
// Parameters:
//    NPADS        number of management GPIO inputs
//    SYNC_STAGES  synchroniser depth (2..4)
//    DB_CNT_W     width of the debounce counters and of db_limit
//
// Ports:
//    wb_clk_i          system clock (single clock domain)
//    wb_rst_i          synchronous, active-high reset
//    mgmt_gpio_in_buf  asynchronous buffered pad inputs
//    db_enable         per-pad debounce enable
//    db_limit          shared debounce length in cycles (quasi-static)
//    irq_rise_en       per-pad rising-edge capture enable
//    irq_fall_en       per-pad falling-edge capture enable
//    edge_clear        per-pad write-1-to-clear pulse for edge_status
//    gpio_in_sync      synchroniser output (last stage)
//    gpio_in_stable    filtered (debounced) level
//    edge_status       sticky captured-edge flags
//    gpio_irq          registered OR of edge_status
// ---------------------------------------------------------------------------
module mgmt_gpio_in_sync #(
   parameter int NPADS       = 19,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CNT_W    = 8
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic [NPADS-1:0]    mgmt_gpio_in_buf,
   input  logic [NPADS-1:0]    db_enable,
   input  logic [DB_CNT_W-1:0] db_limit,
   input  logic [NPADS-1:0]    irq_rise_en,
   input  logic [NPADS-1:0]    irq_fall_en,
   input  logic [NPADS-1:0]    edge_clear,
   output logic [NPADS-1:0]    gpio_in_sync,
   output logic [NPADS-1:0]    gpio_in_stable,
   output logic [NPADS-1:0]    edge_status,
   output logic                gpio_irq
);

   logic [NPADS-1:0]    syncChain [SYNC_STAGES];
   logic [DB_CNT_W-1:0] dbCount   [NPADS];
   logic [DB_CNT_W-1:0] dbCountNext [NPADS];
   logic [NPADS-1:0]    padBypass;
   logic [NPADS-1:0]    padDiff;
   logic [NPADS-1:0]    stableUpdate;
   logic [NPADS-1:0]    riseSet;
   logic [NPADS-1:0]    fallSet;
   logic                limitZero;
   logic [DB_CNT_W-1:0] limitMinusOne;

   // Synchroniser shift chain. Stage 0 samples the raw pad level.
   // The last stage is the first value that is safe to use inside this clock domain.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            syncChain[s] <= '0;
         end
      end else begin
         syncChain[0] <= mgmt_gpio_in_buf;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            syncChain[s] <= syncChain[s-1];
         end
      end
   end

   assign gpio_in_sync = syncChain[SYNC_STAGES-1];

   // A zero limit means "no filtering", exactly like clearing db_enable.
   // The limit-minus-one value is only consulted when the limit is non-zero,
   // so it never underflows in a way that matters.
   assign limitZero     = (db_limit == '0);
   assign limitMinusOne = db_limit - DB_CNT_W'(1);
   assign padBypass     = ~db_enable | {NPADS{limitZero}};
   assign padDiff       = gpio_in_sync ^ gpio_in_stable;

   // Debounce decision for each pad.
   //    - Bypassed pads follow the synchroniser every cycle and keep their counter at 0.
   //    - Filtered pads count consecutive cycles in which the synchronised level differs
   //      from the stable level.
   //    - The filtered level updates once the count reaches db_limit-1.
   // The ">=" compare lets a lowered db_limit release a counter that is already past
   // the new threshold. Incrementing only below the threshold keeps the counter from
   // ever wrapping.
   always_comb begin
      stableUpdate = '0;
      for (int i = 0; i < NPADS; i++) begin
         dbCountNext[i] = '0;
         if (padBypass[i]) begin
            stableUpdate[i] = padDiff[i];
         end else if (padDiff[i]) begin
            if (dbCount[i] >= limitMinusOne) begin
               stableUpdate[i] = 1'b1;
            end else begin
               dbCountNext[i] = dbCount[i] + DB_CNT_W'(1);
            end
         end
      end
   end

   // The new stable level is the synchronised level. A rise or fall is therefore
   // just an update qualified by that new value.
   assign riseSet = stableUpdate &  gpio_in_sync & irq_rise_en;
   assign fallSet = stableUpdate & ~gpio_in_sync & irq_fall_en;

   // Filter state: the debounce counters and the stable level.
   // Reset discards any partial count.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         gpio_in_stable <= '0;
         for (int i = 0; i < NPADS; i++) begin
            dbCount[i] <= '0;
         end
      end else begin
         gpio_in_stable <= (gpio_in_stable & ~stableUpdate) | (gpio_in_sync & stableUpdate);
         for (int i = 0; i < NPADS; i++) begin
            dbCount[i] <= dbCountNext[i];
         end
      end
   end

   // Sticky edge flags and the interrupt.
   // Each flag is set in the same cycle the stable level changes. When a set and a
   // clear hit the same bit together, the set wins, so no edge is ever lost.
   // Changing the enables only gates new captures; it never clears a flag already set.
   // The interrupt is registered, so it trails edge_status by one cycle.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         edge_status <= '0;
         gpio_irq    <= 1'b0;
      end else begin
         edge_status <= (edge_status & ~edge_clear) | riseSet | fallSet;
         gpio_irq    <= |edge_status;
      end
   end

endmodule
